// File: rtl/fusion_alu_pkg.sv
// Shared definitions for the Fusion-Core ALU sequenced blocks.
// Holds the datapath widths and the state encoding of the iterative rotate unit.
package fusion_alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } rotl_state_t;

endpackage

// File: rtl/rotl_step_32.sv
// One rotate-left step with the matching count decrement: one bit per step,
// or four bits per step while at least four remain when ROTL_STEP4_EN is defined.
module rotl_step_32
    import fusion_alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0]   data,
    input  logic [ALU_SHAMT_W-1:0] cnt,
    output logic [ALU_WIDTH-1:0]   rot,
    output logic [ALU_SHAMT_W-1:0] cnt_next
);

    always_comb begin
        rot      = {data[ALU_WIDTH-2:0], data[ALU_WIDTH-1]};
        cnt_next = cnt - 5'd1;
`ifdef ROTL_STEP4_EN
        if (cnt >= 5'd4) begin
            rot      = {data[ALU_WIDTH-5:0], data[ALU_WIDTH-1:ALU_WIDTH-4]};
            cnt_next = cnt - 5'd4;
        end
`endif
    end

endmodule

// File: rtl/rotate_left_iter_32.sv
// Multi-cycle rotate-left unit: rotates the captured operand until the amount is
// consumed, then latches the result and pulses done. Fast stepping under ROTL_STEP4_EN.
module rotate_left_iter_32
    import fusion_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = ALU_SHAMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    rotl_state_t      state;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] step_rot;
    logic [CNT_W-1:0] step_cnt;

    rotl_step_32 u_step (
        .data     (work),
        .cnt      (cnt),
        .rot      (step_rot),
        .cnt_next (step_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work <= a;
                        busy <= 1'b1;
                        if (amount == '0) begin
                            // Nothing to rotate: the result is the operand itself.
                            state <= DONE;
                            out   <= a;
                            done  <= 1'b1;
                        end else begin
                            state <= ROT;
                            cnt   <= amount;
                        end
                    end
                end
                ROT: begin
                    work <= step_rot;
                    cnt  <= step_cnt;
                    if (step_cnt == '0) begin
                        state <= DONE;
                        out   <= step_rot;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_left_iter_32.sv
// Directed bench for rotate_left_iter_32; expected latencies follow ROTL_STEP4_EN
// so the same bench covers both builds.
module tb_rotate_left_iter_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [4:0]  amount;
    logic [31:0] out;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

`ifdef ROTL_STEP4_EN
    localparam int LAT_A1  = 2;
    localparam int LAT_A4  = 2;
    localparam int LAT_A13 = 5;
    localparam int LAT_A31 = 11;
    localparam int LAT_A8  = 3;
`else
    localparam int LAT_A1  = 2;
    localparam int LAT_A4  = 5;
    localparam int LAT_A13 = 14;
    localparam int LAT_A31 = 32;
    localparam int LAT_A8  = 9;
`endif

    rotate_left_iter_32 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .amount (amount),
        .out    (out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one operation and follow it to completion; optionally pulse a
    // stray start with a=0xFFFFFFFF in cycle 10 while the unit is busy.
    task automatic run_op(input string tag, input logic [31:0] op, input logic [4:0] amt,
                          input logic [31:0] exp_out, input int exp_cyc, input bit inject);
        int cyc;
        bit seen;
        @(negedge clk);
        check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
        start  = 1'b1;
        a      = op;
        amount = amt;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = $urandom;
        amount = 5'($urandom);
        cyc    = 1;
        seen   = 1'b0;
        check({tag, " busy c1"}, {31'd0, busy}, 32'd1);
        while (cyc < 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (inject && cyc == 10) begin
                    start = 1'b1;
                    a     = 32'hFFFF_FFFF;
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                cyc++;
            end
        end
        check({tag, " done seen"}, {31'd0, seen}, 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " out"}, out, exp_out);
        check({tag, " busy at done"}, {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, " done fell"}, {31'd0, done}, 32'd0);
        check({tag, " busy fell"}, {31'd0, busy}, 32'd0);
        check({tag, " out held"}, out, exp_out);
    endtask

    initial begin
        bit any_done;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        amount = '0;
        #12;
        check("reset out", out, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("rotl1", 32'h8000_0001, 5'd1, 32'h0000_0003, LAT_A1, 1'b0);
        run_op("rotl4", 32'h1234_5678, 5'd4, 32'h2345_6781, LAT_A4, 1'b0);
        run_op("rotl0", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 1'b0);
        run_op("rotl13", 32'h0000_0001, 5'd13, 32'h0000_2000, LAT_A13, 1'b0);
        run_op("rotl31", 32'h0000_0001, 5'd31, 32'h8000_0000, LAT_A31, 1'b1);

        // Abort an operation with reset in cycle 3.
        @(negedge clk);
        start  = 1'b1;
        a      = 32'h0000_000F;
        amount = 5'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort out", out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) any_done = 1'b1;
        end
        check("abort no done", {31'd0, any_done}, 32'd0);
        check("abort out stays", out, 32'd0);

        run_op("rotl8", 32'h0000_000F, 5'd8, 32'h0000_0F00, LAT_A8, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
